// File: rtl/usb_bus_ctrl.sv
// usb_bus_ctrl: CPU bus responder for the USB window and initiator on the 16-bit async host-controller bus.
// 32-bit accesses become one or two halfword chip cycles with programmable setup/strobe/hold/recover timing.
module usb_bus_ctrl #(
  parameter int unsigned SETUP_CYCLES   = 1,
  parameter int unsigned STROBE_CYCLES  = 3,
  parameter int unsigned HOLD_CYCLES    = 1,
  parameter int unsigned RECOVER_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        mem_cmd_sel,
  input  logic        mem_cmd_valid,
  output logic        mem_cmd_ready,
  input  logic        mem_cmd_wr,
  input  logic [19:0] mem_cmd_addr,
  input  logic [31:0] mem_cmd_wdata,
  input  logic [3:0]  mem_cmd_be,
  output logic        mem_rsp_ready,
  output logic [31:0] mem_rsp_rdata,
  output logic        usb_reset_,
  output logic        usb_cs_,
  output logic        usb_rd_,
  output logic        usb_wr_,
  output logic [16:0] usb_a,
  output logic        usb_d_oe,
  output logic [15:0] usb_d_do,
  input  logic [15:0] usb_d_di,
  input  logic        usb_irq
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_STROBE  = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  localparam logic [3:0] SETUP_LOAD   = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LOAD  = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD    = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] RECOVER_LOAD = 4'(RECOVER_CYCLES - 1);

  logic [2:0]  state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        half_r, half_s;
  logic        wr_r, wr_s;
  logic [1:0]  be_hi_r, be_hi_s;
  logic [15:0] addr_hi_r, addr_hi_s;
  logic [31:0] wdata_r, wdata_s;
  logic [31:0] rdbuf_r;
  logic        irq_meta_r, irq_sync_r;
  logic        accept_s, chip_hit_s, ctrl_hit_s, cycle_act_s, unused_s;

  assign mem_cmd_ready = reset_ & (state_r == ST_IDLE);
  assign accept_s      = mem_cmd_valid & mem_cmd_sel & mem_cmd_ready;
  assign chip_hit_s    = (mem_cmd_addr[19:18] == 2'b00);
  assign ctrl_hit_s    = (mem_cmd_addr[19:18] == 2'b01);
  assign unused_s      = ^mem_cmd_addr[1:0];
  assign cycle_act_s   = (state_s == ST_SETUP) | (state_s == ST_STROBE) | (state_s == ST_HOLD);

  // Command fields: live bus values while idle, the latched copy once a chip access is running
  always_comb begin
    if (state_r == ST_IDLE) begin
      wr_s      = mem_cmd_wr;
      be_hi_s   = mem_cmd_be[3:2];
      addr_hi_s = mem_cmd_addr[17:2];
      wdata_s   = mem_cmd_wdata;
    end else begin
      wr_s      = wr_r;
      be_hi_s   = be_hi_r;
      addr_hi_s = addr_hi_r;
      wdata_s   = wdata_r;
    end
  end

  // Next-state, per-state down-counter and half selection
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    half_s  = half_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && chip_hit_s && !(mem_cmd_wr && (mem_cmd_be == 4'b0000))) begin
          state_s = ST_SETUP;
          cnt_s   = SETUP_LOAD;
          half_s  = mem_cmd_wr && (mem_cmd_be[1:0] == 2'b00);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_STROBE;
          cnt_s   = STROBE_LOAD;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_HOLD;
          cnt_s   = HOLD_LOAD;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_RECOVER;
          cnt_s   = RECOVER_LOAD;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_RECOVER: begin
        if (cnt_r != 4'd0) begin
          cnt_s = cnt_r - 4'd1;
        end else if (!half_r && (!wr_r || (be_hi_r != 2'b00))) begin
          state_s = ST_SETUP;
          cnt_s   = SETUP_LOAD;
          half_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
        half_s  = 1'b0;
      end
    endcase
  end

  // State, command latch, CTRL register, registered chip strobes and CPU response
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 4'd0;
      half_r        <= 1'b0;
      wr_r          <= 1'b0;
      be_hi_r       <= 2'b00;
      addr_hi_r     <= 16'd0;
      wdata_r       <= 32'd0;
      rdbuf_r       <= 32'd0;
      irq_meta_r    <= 1'b0;
      irq_sync_r    <= 1'b0;
      usb_reset_    <= 1'b0;
      usb_cs_       <= 1'b1;
      usb_rd_       <= 1'b1;
      usb_wr_       <= 1'b1;
      usb_a         <= 17'd0;
      usb_d_oe      <= 1'b0;
      usb_d_do      <= 16'd0;
      mem_rsp_ready <= 1'b0;
      mem_rsp_rdata <= 32'd0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      half_r        <= half_s;
      irq_meta_r    <= usb_irq;
      irq_sync_r    <= irq_meta_r;
      mem_rsp_ready <= 1'b0;

      if (accept_s) begin
        wr_r      <= wr_s;
        be_hi_r   <= be_hi_s;
        addr_hi_r <= addr_hi_s;
        wdata_r   <= wdata_s;
        if (ctrl_hit_s) begin
          if (mem_cmd_wr && mem_cmd_be[0]) begin
            usb_reset_ <= mem_cmd_wdata[0];
          end
          if (!mem_cmd_wr) begin
            mem_rsp_ready <= 1'b1;
            mem_rsp_rdata <= {30'd0, irq_sync_r, usb_reset_};
          end
        end else if (!chip_hit_s && !mem_cmd_wr) begin
          mem_rsp_ready <= 1'b1;
          mem_rsp_rdata <= 32'd0;
        end
      end

      usb_cs_  <= ~cycle_act_s;
      usb_rd_  <= ~((state_s == ST_STROBE) & ~wr_s);
      usb_wr_  <= ~((state_s == ST_STROBE) & wr_s);
      usb_d_oe <= cycle_act_s & wr_s;

      // Address and write data are set up once on SETUP entry and held through HOLD
      if ((state_s == ST_SETUP) && (state_r != ST_SETUP)) begin
        usb_a    <= {addr_hi_s, half_s};
        usb_d_do <= half_s ? wdata_s[31:16] : wdata_s[15:0];
      end

      if ((state_r == ST_STROBE) && (cnt_r == 4'd0) && !wr_r) begin
        if (half_r) begin
          rdbuf_r[31:16] <= usb_d_di;
        end else begin
          rdbuf_r[15:0] <= usb_d_di;
        end
      end

      if ((state_r == ST_HOLD) && (cnt_r == 4'd0) && half_r && !wr_r) begin
        mem_rsp_ready <= 1'b1;
        mem_rsp_rdata <= rdbuf_r;
      end
    end
  end

endmodule

// File: tb/tb_usb_bus_ctrl.sv
// Directed self-checking bench for usb_bus_ctrl with default timing (1/3/1/2).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_usb_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset_;
  logic        mem_cmd_sel, mem_cmd_valid, mem_cmd_ready, mem_cmd_wr;
  logic [19:0] mem_cmd_addr;
  logic [31:0] mem_cmd_wdata;
  logic [3:0]  mem_cmd_be;
  logic        mem_rsp_ready;
  logic [31:0] mem_rsp_rdata;
  logic        usb_reset_, usb_cs_, usb_rd_, usb_wr_, usb_d_oe, usb_irq;
  logic [16:0] usb_a;
  logic [15:0] usb_d_do, usb_d_di;

  int checks   = 0;
  int failures = 0;

  usb_bus_ctrl dut (
    .clk(clk), .reset_(reset_),
    .mem_cmd_sel(mem_cmd_sel), .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_wr(mem_cmd_wr), .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata),
    .mem_cmd_be(mem_cmd_be), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata),
    .usb_reset_(usb_reset_), .usb_cs_(usb_cs_), .usb_rd_(usb_rd_), .usb_wr_(usb_wr_),
    .usb_a(usb_a), .usb_d_oe(usb_d_oe), .usb_d_do(usb_d_do), .usb_d_di(usb_d_di), .usb_irq(usb_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one command for a single clock; returns at the sample point of cycle 1
  task automatic issue(input logic wr, input logic [19:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    mem_cmd_valid = 1'b1;
    mem_cmd_sel   = 1'b1;
    mem_cmd_wr    = wr;
    mem_cmd_addr  = addr;
    mem_cmd_wdata = wdata;
    mem_cmd_be    = be;
    @(negedge clk);
    mem_cmd_valid = 1'b0;
    mem_cmd_sel   = 1'b0;
  endtask

  // Bus protocol monitor: exclusive strobes, strobes only inside cs_, full strobe width
  initial begin : mon
    int   run;
    logic aborted;
    run = 0;
    aborted = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset_ === 1'b1) begin
        chk("mon_rd_wr_both_low", {31'd0, ~usb_rd_ & ~usb_wr_}, 32'd0);
        if ((usb_rd_ === 1'b0) || (usb_wr_ === 1'b0)) chk("mon_strobe_without_cs", {31'd0, usb_cs_}, 32'd0);
      end
      if ((usb_rd_ === 1'b0) || (usb_wr_ === 1'b0)) begin
        run++;
        if (reset_ !== 1'b1) aborted = 1'b1;
      end else begin
        if ((run != 0) && !aborted) chk("mon_strobe_width", run, 32'd3);
        run = 0;
        aborted = 1'b0;
      end
    end
  end

  initial begin
    int   wr_low, wr_falls, cs_low, rsp_cnt;
    logic prev_wr;
    reset_ = 1'b0; mem_cmd_sel = 1'b0; mem_cmd_valid = 1'b0; mem_cmd_wr = 1'b0;
    mem_cmd_addr = 20'd0; mem_cmd_wdata = 32'd0; mem_cmd_be = 4'd0;
    usb_d_di = 16'd0; usb_irq = 1'b0;

    // T1 reset
    repeat (20) @(negedge clk);
    chk("rst_cs", usb_cs_, 32'd1);
    chk("rst_rd", usb_rd_, 32'd1);
    chk("rst_wr", usb_wr_, 32'd1);
    chk("rst_oe", usb_d_oe, 32'd0);
    chk("rst_usb_reset", usb_reset_, 32'd0);
    chk("rst_rsp", mem_rsp_ready, 32'd0);
    chk("rst_rdata", mem_rsp_rdata, 32'd0);
    chk("rst_a", usb_a, 32'd0);
    chk("rst_ready_low", mem_cmd_ready, 32'd0);
    reset_ = 1'b1;
    @(negedge clk);
    chk("rst_ready_after", mem_cmd_ready, 32'd1);

    // T2 CTRL register and void accesses
    issue(1'b1, 20'h40000, 32'h0000_0001, 4'hF);
    chk("ctrl_wr_usb_reset", usb_reset_, 32'd1);
    chk("ctrl_wr_no_rsp", mem_rsp_ready, 32'd0);
    chk("ctrl_wr_ready", mem_cmd_ready, 32'd1);
    issue(1'b1, 20'h40000, 32'h0000_0000, 4'b1110);
    chk("ctrl_wr_be0_clear", usb_reset_, 32'd1);
    issue(1'b1, 20'hC0000, 32'h0000_0000, 4'hF);
    chk("void_wr_dropped", usb_reset_, 32'd1);
    chk("void_wr_cs", usb_cs_, 32'd1);
    usb_irq = 1'b1;
    repeat (3) @(negedge clk);
    chk("ctrl_pre_rsp", mem_rsp_ready, 32'd0);
    issue(1'b0, 20'h40000, 32'd0, 4'hF);
    chk("ctrl_rd_rsp", mem_rsp_ready, 32'd1);
    chk("ctrl_rd_data", mem_rsp_rdata, 32'h0000_0003);
    @(negedge clk);
    chk("ctrl_rd_rsp_pulse", mem_rsp_ready, 32'd0);
    issue(1'b0, 20'h80000, 32'd0, 4'hF);
    chk("void_rd_rsp", mem_rsp_ready, 32'd1);
    chk("void_rd_data", mem_rsp_rdata, 32'd0);
    @(negedge clk);

    // T3 32-bit read at 0x00404
    usb_d_di = 16'hBEEF;
    issue(1'b0, 20'h00404, 32'd0, 4'hF);
    for (int c = 1; c <= 15; c++) begin
      if (c > 1) @(negedge clk);
      chk("rd_cs", usb_cs_, {31'd0, (c == 6) || (c == 7) || (c >= 13)});
      chk("rd_rd", usb_rd_, {31'd0, !(((c >= 2) && (c <= 4)) || ((c >= 9) && (c <= 11)))});
      chk("rd_wr", usb_wr_, 32'd1);
      chk("rd_oe", usb_d_oe, 32'd0);
      chk("rd_rsp", mem_rsp_ready, {31'd0, c == 13});
      chk("rd_ready", mem_cmd_ready, {31'd0, c == 15});
      if (c == 1) chk("rd_a_half0", usb_a, 32'h0000_0202);
      if (c == 8) chk("rd_a_half1", usb_a, 32'h0000_0203);
      if (c == 13) chk("rd_rdata", mem_rsp_rdata, 32'hDEAD_BEEF);
      if (c == 7) usb_d_di = 16'hDEAD;
    end

    // T4 upper-half write, lower-half write, and be==0 write
    wr_low = 0; wr_falls = 0; prev_wr = 1'b1;
    issue(1'b1, 20'h00010, 32'h1234_5678, 4'b1100);
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clk);
      if (usb_wr_ === 1'b0) wr_low++;
      if ((prev_wr === 1'b1) && (usb_wr_ === 1'b0)) wr_falls++;
      prev_wr = usb_wr_;
      chk("wr_rd_high", usb_rd_, 32'd1);
      if (c == 1) begin
        chk("wr_a", usb_a, 32'h0000_0009);
        chk("wr_d", usb_d_do, 32'h0000_1234);
        chk("wr_oe_setup", usb_d_oe, 32'd1);
      end
      if (c == 5) chk("wr_oe_hold", usb_d_oe, 32'd1);
      if (c == 6) chk("wr_oe_recover", usb_d_oe, 32'd0);
      if (c == 7) chk("wr_ready_busy", mem_cmd_ready, 32'd0);
      if (c == 8) chk("wr_ready_done", mem_cmd_ready, 32'd1);
      chk("wr_no_rsp", mem_rsp_ready, 32'd0);
    end
    chk("wr_low_cycles", wr_low, 32'd3);
    chk("wr_pulses", wr_falls, 32'd1);
    issue(1'b1, 20'h00010, 32'h1234_5678, 4'b0011);
    chk("wr_lo_a", usb_a, 32'h0000_0008);
    chk("wr_lo_d", usb_d_do, 32'h0000_5678);
    repeat (7) @(negedge clk);
    chk("wr_lo_ready", mem_cmd_ready, 32'd1);
    issue(1'b1, 20'h00010, 32'hFFFF_FFFF, 4'b0000);
    chk("be0_ready", mem_cmd_ready, 32'd1);
    cs_low = 0;
    for (int c = 0; c < 5; c++) begin
      if (usb_cs_ !== 1'b1) cs_low++;
      @(negedge clk);
    end
    chk("be0_no_cycle", cs_low, 32'd0);

    // T5 valid held across two reads
    usb_d_di = 16'h5A5A;
    mem_cmd_valid = 1'b1; mem_cmd_sel = 1'b1; mem_cmd_wr = 1'b0;
    mem_cmd_addr = 20'h00008; mem_cmd_be = 4'hF;
    rsp_cnt = 0;
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk);
      chk("b2b_ready", mem_cmd_ready, {31'd0, (c == 15) || (c >= 30)});
      chk("b2b_rsp", mem_rsp_ready, {31'd0, (c == 13) || (c == 28)});
      if (mem_rsp_ready === 1'b1) begin
        rsp_cnt++;
        chk("b2b_rdata", mem_rsp_rdata, 32'h5A5A_5A5A);
      end
      if (c == 15) begin
        @(posedge clk);
        #1;
        mem_cmd_valid = 1'b0;
        mem_cmd_sel   = 1'b0;
      end
    end
    chk("b2b_rsp_count", rsp_cnt, 32'd2);

    // T6 reset during STROBE
    issue(1'b0, 20'h00404, 32'd0, 4'hF);
    repeat (2) @(negedge clk);
    chk("abort_in_strobe", usb_rd_, 32'd0);
    reset_ = 1'b0;
    @(negedge clk);
    chk("abort_rd", usb_rd_, 32'd1);
    chk("abort_cs", usb_cs_, 32'd1);
    chk("abort_oe", usb_d_oe, 32'd0);
    chk("abort_a", usb_a, 32'd0);
    chk("abort_ready", mem_cmd_ready, 32'd0);
    @(negedge clk);
    reset_ = 1'b1;
    rsp_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (mem_rsp_ready !== 1'b0) rsp_cnt++;
      @(negedge clk);
    end
    chk("abort_no_rsp", rsp_cnt, 32'd0);
    chk("abort_idle_ready", mem_cmd_ready, 32'd1);
    usb_d_di = 16'h2468;
    issue(1'b0, 20'h00000, 32'd0, 4'hF);
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 7) usb_d_di = 16'h1357;
    end
    chk("post_abort_rsp", mem_rsp_ready, 32'd1);
    chk("post_abort_rdata", mem_rsp_rdata, 32'h1357_2468);
    repeat (2) @(negedge clk);
    chk("post_abort_ready", mem_cmd_ready, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
